div_iter_unit: RTL and testbench
================================

// Module: div_iter_unit
// PURPOSE
//  Iterative 32-bit signed/unsigned divider in the EX stage of the 5-stage MIPS core.
//  The hazard unit issues stalls and flushes; this block is the other end of that link.
//  It raises a stall request toward the hazard unit while a DIV/DIVU is in flight.
//  It obeys flushE by annulling the operation. The result goes to the HI/LO write path
//  for one cycle when the operation completes.
// PARAMETERS
//  WIDTH    32  operand/result width
//  CNT_W    6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk          in   1      core clock, rising edge
//  rst          in   1      synchronous active-high reset
//  div_startE   in   1      DIV/DIVU instruction valid in EX
//  div_signedE  in   1      1 = DIV (signed), 0 = DIVU
//  flushE       in   1      annul EX-stage work from the hazard unit
//  srcaE        in   WIDTH  dividend (rs, after forwarding)
//  srcbE        in   WIDTH  divisor (rt, after forwarding)
//  stall_divE   out  1      stall request to the hazard unit (OR'd into stallF/stallD/stallE)
//  div_validE   out  1      HI/LO write strobe, one cycle
//  div_hiE      out  WIDTH  remainder
//  div_loE      out  WIDTH  quotient
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, stall_divE=0, div_validE=0, div_hiE=0, div_loE=0.
//  FSM: IDLE, BUSY, DONE.
//  IDLE:
//   - div_startE & ~flushE & srcbE!=0 -> BUSY. Latch |a|, |b|, the sign flags and the op type.
//     Clear the remainder register (WIDTH+1 bits) and the counter.
//   - div_startE & ~flushE & srcbE==0 -> DONE. div_hiE=srcaE, div_loE=all-ones; no iteration.
//  BUSY: one restoring step per cycle.
//   - rem = {rem,q_msb} - b; if rem>=0, keep it and shift 1 into q; else restore and shift 0.
//   - The counter increments each step. counter==WIDTH-1 -> DONE.
//  DONE: result registers are stable and div_validE=1 for exactly this cycle. Next state IDLE.
//  Sign fix-up, applied on the BUSY->DONE edge and only when signed:
//   - Quotient is negated if the operand signs differ.
//   - Remainder takes the dividend's sign.
//   - 0x80000000 / 0xFFFFFFFF signed gives lo=0x80000000, hi=0 (two's-complement wrap, no trap).
//  stall_divE = (IDLE & div_startE & ~flushE) | BUSY. It is combinational from state and inputs,
//   so the starting cycle already stalls. It is 0 in DONE, so the DIV leaves EX on the DONE edge.
//  Latency: start seen at cycle 0 -> div_validE at cycle WIDTH+1 (33), stall high cycles 0..32.
//   Divide-by-zero: div_validE at cycle 1, stall high in cycle 0 only.
//  Operands are latched at start. srcaE/srcbE changes during BUSY are ignored.
//  flushE in BUSY or DONE -> IDLE next cycle. div_validE is forced 0 in that cycle;
//   stall_divE drops the same cycle.
//  div_startE in DONE is ignored. It cannot happen legally, because the pipeline advances on
//   the DONE edge and a back-to-back DIV is seen in IDLE one cycle later.
//  rst in any state -> reset values next edge. An in-flight result is discarded.
//  div_hiE/div_loE hold their last value outside DONE. Consumers use div_validE only.
// STRUCTURE
//  Shared package: FSM state encodings (IDLE/BUSY/DONE) and the div-by-zero quotient constant.
//   The decoder uses the same package for its DIV/DIVU funct codes.
//  One natural sub-module: div_abs_neg, a combinational conditional two's-complement negate.
//   It is instanced for operand abs and result fix-up.
//  Everything else (FSM, counter, datapath) stays flat in this module.
// TESTING
//  1. DIVU 100/7 -> stall_divE high 33 cycles, then div_validE=1 with lo=14, hi=2.
//  2. DIV -7/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//     Also DIV 7/-2 -> lo=-3, hi=1.
//  3. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//     Also DIVU 0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0.
//  4. DIVU 5/0 -> div_validE at cycle 1, hi=5, lo=0xFFFFFFFF, stall for 1 cycle only.
//  5. Start DIVU 100/7, assert flushE at cycle 10 -> IDLE at cycle 11, stall_divE=0,
//     no div_validE.
//     Then a new DIVU 9/3 returns lo=3, hi=0 with full 33-cycle latency.
//  6. Back-to-back DIVs -> second stall starts the cycle after DONE.
//     rst at cycle 20 of a DIV -> all outputs 0 next cycle, no div_validE.

Source files
------------

// File: rtl/div_iter_unit_pkg.sv
// ---------------------------------------------------------------------------
// div_iter_unit_pkg
//   Shared definitions for the EX-stage iterative divider and the decoder.
//   - div_state_t    : divider FSM encodings (IDLE/BUSY/DONE)
//   - DIV_ZERO_QUOT  : quotient returned for a zero divisor
//   - FUNCT_DIV/DIVU : R-type funct codes recognised by the decoder
// ---------------------------------------------------------------------------
package div_iter_unit_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    // Divide-by-zero does not trap: the quotient reads as all ones.
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = {DIV_WIDTH{1'b1}};

    localparam logic [5:0] FUNCT_DIV  = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU = 6'h1B;

    // True for either divide funct code.
    function automatic logic is_div_funct(input logic [5:0] funct);
        return (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/div_iter_unit_abs_neg.sv
// ---------------------------------------------------------------------------
// div_abs_neg
//   Combinational conditional two's-complement negate.
//   Ports:
//     i_val  in  WIDTH  value
//     i_neg  in  1      1 = output -i_val, 0 = pass through
//     o_val  out WIDTH  result
// ---------------------------------------------------------------------------
module div_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);

    always_comb begin
        o_val = i_val;
        if (i_neg) begin
            o_val = ~i_val + WIDTH'(1);
        end
    end

endmodule

// File: rtl/div_iter_unit.sv
// ---------------------------------------------------------------------------
// div_iter_unit
//   Iterative restoring divider (DIV/DIVU) in the EX stage. Holds the
//   pipeline through stall_divE while a divide is in flight and produces a
//   one-cycle HI/LO write strobe on completion.
//   Ports:
//     clk          in   1      core clock, rising edge
//     rst          in   1      synchronous active-high reset
//     div_startE   in   1      DIV/DIVU valid in EX
//     div_signedE  in   1      1 = DIV, 0 = DIVU
//     flushE       in   1      annul EX work
//     srcaE        in   WIDTH  dividend
//     srcbE        in   WIDTH  divisor
//     stall_divE   out  1      stall request to hazard unit
//     div_validE   out  1      HI/LO write strobe
//     div_hiE      out  WIDTH  remainder
//     div_loE      out  WIDTH  quotient
//     dbg_stateE   out  2      current FSM state (observation only)
//   Handshake: a request is accepted in IDLE when div_startE=1 and
//   flushE=0; the instruction stays in EX while stall_divE=1 and the
//   result is valid for exactly the single cycle div_validE=1.
// ---------------------------------------------------------------------------
module div_iter_unit
    import div_iter_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_startE,
    input  logic             div_signedE,
    input  logic             flushE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    output logic             stall_divE,
    output logic             div_validE,
    output logic [WIDTH-1:0] div_hiE,
    output logic [WIDTH-1:0] div_loE,
    output div_state_t       dbg_stateE
);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_rem;     // partial remainder, one guard bit
    logic [WIDTH-1:0] r_q;       // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] r_b;       // |divisor|
    logic             r_neg_q;   // negate quotient at fix-up
    logic             r_neg_r;   // negate remainder at fix-up
    logic             r_valid;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_accept;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_take;
    logic [WIDTH:0]   w_rem_next;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic             w_last;

    assign w_accept = (r_state == ST_IDLE) && div_startE && !flushE;
    assign w_b_zero = (srcbE == '0);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // Operand magnitudes; 0x80000000 maps onto itself, which is the
    // correct unsigned magnitude.
    div_abs_neg #(.WIDTH(WIDTH)) u_abs_a (
        .i_val (srcaE),
        .i_neg (div_signedE & srcaE[WIDTH-1]),
        .o_val (w_a_abs)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_abs_b (
        .i_val (srcbE),
        .i_neg (div_signedE & srcbE[WIDTH-1]),
        .o_val (w_b_abs)
    );

    // Restoring step. Two extra bits keep the trial's sign unambiguous:
    // the shifted remainder can reach 2*b-1 while b can be 2**WIDTH-1.
    assign w_shift    = {r_rem, r_q[WIDTH-1]};
    assign w_trial    = w_shift - {2'b00, r_b};
    assign w_take     = ~w_trial[WIDTH+1];
    assign w_rem_next = w_take ? w_trial[WIDTH:0] : w_shift[WIDTH:0];
    assign w_q_next   = {r_q[WIDTH-2:0], w_take};

    // Sign fix-up applied to the values produced by the final step.
    div_abs_neg #(.WIDTH(WIDTH)) u_fix_q (
        .i_val (w_q_next),
        .i_neg (r_neg_q),
        .o_val (w_q_fix)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_fix_r (
        .i_val (w_rem_next[WIDTH-1:0]),
        .i_neg (r_neg_r),
        .o_val (w_r_fix)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_b     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_valid <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_valid <= 1'b0;
                    if (w_accept) begin
                        if (w_b_zero) begin
                            r_hi    <= srcaE;
                            r_lo    <= DIV_ZERO_QUOT;
                            r_valid <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_q     <= w_a_abs;
                            r_b     <= w_b_abs;
                            r_neg_q <= div_signedE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
                            r_neg_r <= div_signedE & srcaE[WIDTH-1];
                            r_rem   <= '0;
                            r_cnt   <= '0;
                            r_state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (flushE) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_rem <= w_rem_next;
                        r_q   <= w_q_next;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_lo    <= w_q_fix;
                            r_hi    <= w_r_fix;
                            r_valid <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // A start seen here is not legal and is dropped.
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall is combinational so the accepting cycle already holds the
    // pipeline; a flush releases it in the same cycle.
    assign stall_divE = !flushE &&
                        ((r_state == ST_BUSY) || ((r_state == ST_IDLE) && div_startE));

    // A flush in DONE annuls the strobe in that very cycle.
    assign div_validE = r_valid && !flushE;
    assign div_hiE    = r_hi;
    assign div_loE    = r_lo;
    assign dbg_stateE = r_state;

endmodule

// File: tb/tb_div_iter_unit.sv
module tb_div_iter_unit;
    import div_iter_unit_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         div_startE;
    logic         div_signedE;
    logic         flushE;
    logic [W-1:0] srcaE;
    logic [W-1:0] srcbE;
    logic         stall_divE;
    logic         div_validE;
    logic [W-1:0] div_hiE;
    logic [W-1:0] div_loE;
    div_state_t   dbg_stateE;

    logic [2*W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    bit tests_done = 0;

    div_iter_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .div_startE  (div_startE),
        .div_signedE (div_signedE),
        .flushE      (flushE),
        .srcaE       (srcaE),
        .srcbE       (srcbE),
        .stall_divE  (stall_divE),
        .div_validE  (div_validE),
        .div_hiE     (div_hiE),
        .div_loE     (div_loE),
        .dbg_stateE  (dbg_stateE)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- comparison helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [2*W-1:0] e;
        forever begin
            @(negedge clk);
            if (div_validE) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 64'(div_validE), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("hi", 64'(div_hiE), 64'(e[2*W-1:W]));
                    check("lo", 64'(div_loE), 64'(e[W-1:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Issues one divide, pushes its expected result and checks stall and
    // strobe timing. Cycle 0 is the cycle in which div_startE is seen.
    task automatic do_div(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo,
                          input int elat);
        int cycles;
        int stalls;
        bit got;
        @(posedge clk); #1;
        div_startE  = 1'b1;
        div_signedE = sg;
        srcaE       = a;
        srcbE       = b;
        exp_q.push_back({ehi, elo});
        cycles = 0;
        stalls = 0;
        got    = 0;
        @(negedge clk);
        if (stall_divE) stalls++;
        @(posedge clk); #1;
        div_startE = 1'b0;
        // Operands must have been latched; scramble the inputs.
        srcaE = $urandom_range(32'hFFFF_FFFF, 0);
        srcbE = $urandom_range(32'hFFFF_FFFF, 0);
        while (!got && cycles < 100) begin
            cycles++;
            if (cycles > 1) @(posedge clk);
            @(negedge clk);
            if (div_validE) got = 1;
            else if (stall_divE) stalls++;
        end
        check("latency", 64'(cycles), 64'(elat));
        check("stall_cycles", 64'(stalls), 64'(elat));
        check("stall_in_done", 64'(stall_divE), 64'd0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; div_startE = 1'b0; div_signedE = 1'b0; flushE = 1'b0;
        srcaE = '0; srcbE = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", 64'(dbg_stateE), 64'(ST_IDLE));
        check("rst_stall", 64'(stall_divE), 64'd0);
        check("rst_valid", 64'(div_validE), 64'd0);
        check("rst_hi", 64'(div_hiE), 64'd0);
        check("rst_lo", 64'(div_loE), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed vectors: signed, a, b, hi, lo, latency.
        do_div(1'b0, 32'd100,        32'd7,          32'd2,          32'd14,         33);
        do_div(1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  33);
        do_div(1'b1, 32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD,  33);
        do_div(1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33);
        do_div(1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'hFFFF_FFFF,  33);
        do_div(1'b0, 32'h1234_5678,  32'h100,        32'h78,         32'h0012_3456,  33);
        do_div(1'b0, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF,  1);
        do_div(1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  32'hFFFF_FFFF,  1);
        idle_cycles(2);

        // Flush at cycle 10 of a DIVU 100/7: no result may appear.
        @(posedge clk); #1;
        div_startE = 1'b1; div_signedE = 1'b0; srcaE = 32'd100; srcbE = 32'd7;
        @(posedge clk); #1;
        div_startE = 1'b0;
        repeat (9) @(posedge clk);
        #1 flushE = 1'b1;
        @(negedge clk);
        check("flush_stall_drop", 64'(stall_divE), 64'd0);
        check("flush_valid", 64'(div_validE), 64'd0);
        @(posedge clk); #1;
        flushE = 1'b0;
        @(negedge clk);
        check("flush_state", 64'(dbg_stateE), 64'(ST_IDLE));
        check("flush_stall_after", 64'(stall_divE), 64'd0);
        idle_cycles(40);
        do_div(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 33);

        // Back-to-back: second start lands the cycle after DONE.
        do_div(1'b0, 32'd1000,       32'd10,         32'd0,          32'd100,        33);
        do_div(1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFF2,  33);

        // Reset at cycle 20 of a divide: result discarded, outputs cleared.
        @(posedge clk); #1;
        div_startE = 1'b1; div_signedE = 1'b0; srcaE = 32'd100; srcbE = 32'd7;
        @(posedge clk); #1;
        div_startE = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_state", 64'(dbg_stateE), 64'(ST_IDLE));
        check("mid_rst_stall", 64'(stall_divE), 64'd0);
        check("mid_rst_valid", 64'(div_validE), 64'd0);
        check("mid_rst_hi", 64'(div_hiE), 64'd0);
        check("mid_rst_lo", 64'(div_loE), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycles(40);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        tests_done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
